// File: rtl/cpu_pkg.sv
// Shared CPU types for the multiply/divide unit: operation codes, controller
// FSM states and small operand helpers.
package cpu_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        MADD  = 3'd2,
        MADDU = 3'd3,
        MSUB  = 3'd4,
        MSUBU = 3'd5,
        MTHI  = 3'd6,
        MTLO  = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FIX   = 2'd3
    } mdu_state_t;

    function automatic logic is_mul_op(input mdu_op_t op);
        return (op != MTHI) && (op != MTLO);
    endfunction

    function automatic logic is_signed_op(input mdu_op_t op);
        return (op == MULT) || (op == MADD) || (op == MSUB);
    endfunction

    // Two's-complement magnitude; the most negative value maps onto itself,
    // which is exactly 2^31 when read as unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair, written as one 64-bit word.
module hilo_reg (
    input  logic        clk,
    input  logic        resetn,
    input  logic        we,
    input  logic [63:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] hilo_r;

    // HI/LO storage with synchronous clear
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hilo_r <= 64'd0;
        end else if (we) begin
            hilo_r <= wdata;
        end
    end

    assign hi = hilo_r[63:32];
    assign lo = hilo_r[31:0];

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide-unit controller: sequences an external unsigned 32x32
// multiplier and applies sign fix-up and HI/LO accumulation.
module mdu_ctrl
    import cpu_pkg::*;
#(
    parameter bit ACC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  mdu_op_t     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_valid,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_done,
    input  logic [63:0] mul_c
);

    mdu_state_t  state_r, state_s;
    mdu_op_t     op_r;
    logic        neg_r;
    logic [31:0] mul_a_r, mul_b_r;
    logic [63:0] prod_r;
    logic        busy_r, mul_valid_r;

    logic [63:0] hilo_s, p_s, fix_data_s, wr_data_s;
    logic        wr_en_s, latch_s, capture_s;

    assign hilo_s = {hi, lo};

    // Product sign restoration and accumulation into the current HI/LO
    always_comb begin
        p_s        = neg_r ? (64'd0 - prod_r) : prod_r;
        fix_data_s = p_s;
        case (op_r)
            MADD, MADDU: begin
                if (ACC_EN) fix_data_s = hilo_s + p_s;
                else        fix_data_s = p_s;
            end
            MSUB, MSUBU: begin
                if (ACC_EN) fix_data_s = hilo_s - p_s;
                else        fix_data_s = p_s;
            end
            default: fix_data_s = p_s;
        endcase
    end

    // Next-state and HI/LO write decode; flush overrides everything
    always_comb begin
        state_s   = state_r;
        wr_en_s   = 1'b0;
        wr_data_s = hilo_s;
        latch_s   = 1'b0;
        capture_s = 1'b0;
        if (flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && is_mul_op(op)) begin
                        latch_s = 1'b1;
                        state_s = ISSUE;
                    end else if (start) begin
                        wr_en_s   = 1'b1;
                        wr_data_s = (op == MTHI) ? {a, lo} : {hi, a};
                    end else begin
                        state_s = IDLE;
                    end
                end
                ISSUE: state_s = WAIT;
                WAIT: begin
                    if (mul_done) begin
                        capture_s = 1'b1;
                        state_s   = FIX;
                    end else begin
                        state_s = WAIT;
                    end
                end
                FIX: begin
                    wr_en_s   = 1'b1;
                    wr_data_s = fix_data_s;
                    state_s   = IDLE;
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State, operand latches and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= IDLE;
            op_r        <= MULT;
            neg_r       <= 1'b0;
            mul_a_r     <= 32'd0;
            mul_b_r     <= 32'd0;
            prod_r      <= 64'd0;
            busy_r      <= 1'b0;
            mul_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            busy_r      <= (state_s != IDLE);
            mul_valid_r <= (state_s == ISSUE);
            if (latch_s) begin
                op_r    <= op;
                neg_r   <= is_signed_op(op) & (a[31] ^ b[31]);
                mul_a_r <= is_signed_op(op) ? abs32(a) : a;
                mul_b_r <= is_signed_op(op) ? abs32(b) : b;
            end
            if (capture_s) begin
                prod_r <= mul_c;
            end
        end
    end

    hilo_reg u_hilo (
        .clk    (clk),
        .resetn (resetn),
        .we     (wr_en_s),
        .wdata  (wr_data_s),
        .hi     (hi),
        .lo     (lo)
    );

    assign busy      = busy_r;
    assign mul_valid = mul_valid_r;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl with a 1-cycle multiplier model.
module tb_mdu_ctrl;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, start, flush, mul_done;
    mdu_op_t     op;
    logic [31:0] a, b, hi, lo, mul_a, mul_b;
    logic        busy, mul_valid;
    logic [63:0] mul_c;
    logic        mul_auto, stray_req;

    int errors = 0;
    int checks = 0;

    logic        bz [1:4];
    logic        mv [1:4];
    logic [31:0] ma, mb;

    mdu_ctrl #(.ACC_EN(1'b1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .hi(hi), .lo(lo), .mul_valid(mul_valid),
        .mul_a(mul_a), .mul_b(mul_b), .mul_done(mul_done), .mul_c(mul_c)
    );

    always #5 clk = ~clk;

    // Unsigned multiplier: answers one cycle after its start pulse
    always @(posedge clk) begin
        mul_done <= (mul_valid && mul_auto) || stray_req;
        if (mul_valid && mul_auto)
            mul_c <= {32'd0, mul_a} * {32'd0, mul_b};
    end

    // Issue one op at cycle 0 and record busy/mul_valid for cycles 1..4
    task automatic do_op(input mdu_op_t o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            bz[c] = busy;
            mv[c] = mul_valid;
            if (c == 1) begin ma = mul_a; mb = mul_b; end
        end
    endtask

    task automatic do_mt(input mdu_op_t o, input logic [31:0] x);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = 32'd0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'd0); end
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'd0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (mul_valid !== 1'b0) begin errors++; $display("FAIL reset_mul_valid got=%b exp=0", mul_valid); end
        checks++; if ({mul_a, mul_b} !== 64'd0) begin errors++; $display("FAIL reset_mul_ab got=%h exp=0", {mul_a, mul_b}); end
        resetn = 1'b1;
    endtask

    task automatic test_multu();
        do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if ({bz[1], bz[2], bz[3], bz[4]} !== 4'b1110) begin errors++; $display("FAIL multu_busy got=%b%b%b%b exp=1110", bz[1], bz[2], bz[3], bz[4]); end
        checks++; if ({mv[1], mv[2], mv[3], mv[4]} !== 4'b1000) begin errors++; $display("FAIL multu_valid got=%b%b%b%b exp=1000", mv[1], mv[2], mv[3], mv[4]); end
        checks++; if (ma !== 32'hFFFF_FFFF) begin errors++; $display("FAIL multu_mul_a got=%h exp=ffffffff", ma); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got=%h exp=fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got=%h exp=00000001", lo); end
    endtask

    task automatic test_mult_signed();
        do_op(MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        checks++; if (ma !== 32'd2) begin errors++; $display("FAIL mult_neg_mul_a got=%h exp=2", ma); end
        checks++; if (mb !== 32'd3) begin errors++; $display("FAIL mult_neg_mul_b got=%h exp=3", mb); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_neg_lo got=%h exp=fffffffa", lo); end
        do_op(MULT, 32'h8000_0000, 32'h8000_0000);
        checks++; if (ma !== 32'h8000_0000) begin errors++; $display("FAIL mult_min_mul_a got=%h exp=80000000", ma); end
        checks++; if (hi !== 32'h4000_0000) begin errors++; $display("FAIL mult_min_hi got=%h exp=40000000", hi); end
        checks++; if (lo !== 32'h0000_0000) begin errors++; $display("FAIL mult_min_lo got=%h exp=0", lo); end
    endtask

    task automatic test_accumulate();
        do_mt(MTHI, 32'd1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL mthi_hi got=%h exp=1", hi); end
        do_mt(MTLO, 32'd0);
        checks++; if (lo !== 32'd0) begin errors++; $display("FAIL mtlo_lo got=%h exp=0", lo); end
        do_op(MSUBU, 32'd1, 32'd2);
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL msubu_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL msubu_lo got=%h exp=fffffffe", lo); end
        do_mt(MTHI, 32'd0);
        do_mt(MTLO, 32'd0);
        do_op(MADD, 32'hFFFF_FFFF, 32'd1);
        checks++; if (ma !== 32'd1) begin errors++; $display("FAIL madd_mul_a got=%h exp=1", ma); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL madd_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL madd_lo got=%h exp=ffffffff", lo); end
    endtask

    task automatic test_flush();
        do_mt(MTHI, 32'h0000_1234);
        do_mt(MTLO, 32'h0000_5678);
        mul_auto = 1'b0;
        @(negedge clk);
        start = 1'b1; op = MULTU; a = 32'd7; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_wait_busy got=%b exp=1", busy); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
        stray_req = 1'b1;
        @(negedge clk);
        stray_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_stray_busy got=%b exp=0", busy); end
        checks++; if (hi !== 32'h0000_1234) begin errors++; $display("FAIL flush_hi got=%h exp=00001234", hi); end
        checks++; if (lo !== 32'h0000_5678) begin errors++; $display("FAIL flush_lo got=%h exp=00005678", lo); end
        mul_auto = 1'b1;
    endtask

    task automatic test_busy_ignore();
        @(negedge clk);
        start = 1'b1; op = MULTU; a = 32'd2; b = 32'd3;
        @(negedge clk);
        op = MTHI; a = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ignore_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL ignore_lo got=%h exp=6", lo); end
    endtask

    task automatic test_reset_in_fix();
        do_mt(MTHI, 32'h0000_00AA);
        @(negedge clk);
        start = 1'b1; op = MADDU; a = 32'd4; b = 32'd4;
        repeat (3) @(negedge clk);
        start = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL fixrst_hilo got=%h exp=0", {hi, lo}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fixrst_busy got=%b exp=0", busy); end
        do_op(MULTU, 32'd3, 32'd5);
        checks++; if (lo !== 32'd15) begin errors++; $display("FAIL fixrst_multu_lo got=%h exp=0000000f", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL fixrst_multu_hi got=%h exp=0", hi); end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; op = MULT; a = 32'd0; b = 32'd0; flush = 1'b0;
        mul_auto = 1'b1; stray_req = 1'b0;
        test_reset();
        test_multu();
        test_mult_signed();
        test_accumulate();
        test_flush();
        test_busy_ignore();
        test_reset_in_fix();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
